spart_echo_driver: RTL and testbench

Parametrised bus-master driver for the SPART UART peripheral. After reset it programs the baud-rate divisor selected by `br_cfg`, then echoes every received character back through the transmitter via an internal FIFO. Unlike the first-generation driver, it is generic in clock frequency, data width and buffer depth, and can reprogram the divisor when `br_cfg` changes. It sits between the board switches and the SPART `iocs/iorw/ioaddr/databus` port.

---
 rtl/spart_echo_driver.sv | 149 ++++++++++++++
 tb/tb_spart_echo_driver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spart_echo_driver.sv
// SPART bus-master echo driver: programs the baud divisor, then echoes RX bytes to TX via a FIFO.
// Optional divisor reprogramming on br_cfg change: define SPART_DRV_BRCFG_TRACK_EN.
module spart_echo_driver #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        br_cfg,
  input  logic              rda,
  input  logic              tbr,
  output logic              iocs,
  output logic              iorw,
  output logic [1:0]        ioaddr,
  inout  wire  [DATA_W-1:0] databus
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int DW2 = 2 * DATA_W;
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [2:0] {PROG_LO, PROG_HI, IDLE, RD, WR, GAP} state_t;

  function automatic logic [DW2-1:0] div_of(input logic [1:0] sel);
    int baud;
    baud = 4800 << sel;
    return DW2'((CLK_HZ + 8 * baud) / (16 * baud) - 1);
  endfunction

  // state holds the bus cycle to be issued on the next edge; outputs are registered with it
  state_t            state;
  logic [DATA_W-1:0] dout;
  logic [DW2-1:0]    div_q;
  logic [DW2-1:0]    div_now;
  logic              first;
  logic [1:0]        br_q;
  logic [1:0]        sel;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wp, rp;
  logic              full, empty, push, pop;

  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty   = (wp == rp);
  assign push    = iocs && iorw && (ioaddr == 2'b00);
  assign pop     = iocs && !iorw && (ioaddr == 2'b00);
  assign databus = (iocs && !iorw) ? dout : {DATA_W{1'bz}};

  // the very first program uses the live input since br_q has not been loaded yet
  assign sel = first ? br_cfg : br_q;

  always_comb begin
    div_now = div_of(sel);
  end

`ifdef SPART_DRV_BRCFG_TRACK_EN
  logic reprog;
  logic chg;
  assign chg = !first && (br_cfg != br_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) br_q <= 2'b00;
    else     br_q <= br_cfg;
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        br_q <= 2'b00;
    else if (first) br_q <= br_cfg;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= PROG_LO;
      iocs   <= 1'b0;
      iorw   <= 1'b1;
      ioaddr <= 2'b00;
      dout   <= '0;
      div_q  <= '0;
      first  <= 1'b1;
`ifdef SPART_DRV_BRCFG_TRACK_EN
      reprog <= 1'b0;
`endif
    end else begin
      iocs   <= 1'b0;
      iorw   <= 1'b1;
      ioaddr <= 2'b00;
`ifdef SPART_DRV_BRCFG_TRACK_EN
      if (chg) reprog <= 1'b1;
`endif
      case (state)
        PROG_LO: begin
          iocs   <= 1'b1;
          iorw   <= 1'b0;
          ioaddr <= 2'b10;
          dout   <= div_now[DATA_W-1:0];
          div_q  <= div_now;
          first  <= 1'b0;
          state  <= PROG_HI;
        end
        PROG_HI: begin
          iocs   <= 1'b1;
          iorw   <= 1'b0;
          ioaddr <= 2'b11;
          dout   <= div_q[DW2-1:DATA_W];
          state  <= IDLE;
        end
        IDLE: begin
`ifdef SPART_DRV_BRCFG_TRACK_EN
          if (reprog) begin
            state  <= PROG_LO;
            reprog <= chg;
          end else
`endif
          if (rda && !full)       state <= RD;
          else if (tbr && !empty) state <= WR;
          else                    state <= IDLE;
        end
        RD: begin
          iocs  <= 1'b1;
          iorw  <= 1'b1;
          state <= GAP;
        end
        WR: begin
          iocs  <= 1'b1;
          iorw  <= 1'b0;
          dout  <= mem[rp[AW-1:0]];
          state <= GAP;
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + PTR_ONE;
      if (pop)  rp <= rp + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= databus;
  end
endmodule

// File: tb/tb_spart_echo_driver.sv
// Bench for spart_echo_driver: SPART bus model, echo scoreboard, directed and random traffic.
module tb_spart_echo_driver;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic       rda, tbr;
  wire        iocs, iorw;
  wire  [1:0] ioaddr;
  wire  [7:0] databus;
  logic [7:0] drv;

  assign databus = (iocs && iorw && ioaddr == 2'b00) ? drv : 8'hzz;

  spart_echo_driver dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .rda(rda), .tbr(tbr),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus)
  );

  always #5 clk = ~clk;

  int vec = 0, err = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vec++;
    if (obs !== want) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  typedef struct {int c; logic [1:0] a; logic [7:0] d;} wr_t;
  wr_t        wr_log[$];
  int         rd_log[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         outst = 0;
  int         last_acc = -10;

  function automatic int ref_div(input int baud);
    return (50_000_000 + 8 * baud) / (16 * baud) - 1;
  endfunction

  // SPART side: supplies RX bytes on reads, logs writes, checks echo order and bus discipline
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst) begin
      outst    = 0;
      last_acc = -10;
    end
    if (!iocs) begin
      chk("idle_bus", {iorw, ioaddr, databus === 8'hzz}, 32'h9);
    end else if (iorw) begin
      chk("rd_addr", ioaddr, 2'b00);
      chk("rd_spacing", (cyc - last_acc) >= 2, 1);
      chk("rd_has_data", rx_q.size() != 0, 1);
      rd_log.push_back(cyc);
      last_acc = cyc;
      if (rx_q.size() != 0) drv = rx_q.pop_front();
      rda = (rx_q.size() != 0);
      outst++;
      chk("fifo_bound", outst <= 4, 1);
    end else begin
      wr_log.push_back('{c: cyc, a: ioaddr, d: databus});
      if (ioaddr == 2'b00) begin
        chk("wr_spacing", (cyc - last_acc) >= 2, 1);
        last_acc = cyc;
        outst--;
        chk("echo_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("echo_data", databus, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] b);
    rx_q.push_back(b);
    exp_q.push_back(b);
    rda = 1'b1;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rd_log.delete();
  endtask

  task automatic chk_wr(input string tag, input int idx, input int c,
                        input logic [1:0] a, input logic [7:0] d);
    if (idx < wr_log.size()) begin
      chk({tag, "_addr"}, wr_log[idx].a, a);
      chk({tag, "_data"}, wr_log[idx].d, d);
      if (c >= 0) chk({tag, "_cyc"}, wr_log[idx].c, c);
    end else begin
      chk({tag, "_missing"}, wr_log.size(), idx + 1);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rel, e, d;
    logic [7:0] lo, hi;
    bit seen;
    rst = 1'b1; br_cfg = 2'b01; rda = 1'b0; tbr = 1'b1; drv = 8'h00;

    // reset release, 9600 baud
    repeat (3) @(posedge clk);
    #2;
    chk("rst_iocs", iocs, 0);
    chk("rst_iorw", iorw, 1);
    chk("rst_addr", ioaddr, 0);
    chk("rst_hiz", databus === 8'hzz, 1);
    clear_logs();
    rel = cyc;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    d = ref_div(9600); lo = d[7:0]; hi = d[15:8];
    chk("t1_count", wr_log.size(), 2);
    chk_wr("t1_lo", 0, rel + 1, 2'b10, lo);
    chk_wr("t1_hi", 1, rel + 2, 2'b11, hi);
    chk("t1_no_rd", rd_log.size(), 0);

    // single echo latency
    clear_logs();
    @(negedge clk);
    e = cyc + 1;
    send(8'h41);
    repeat (10) @(negedge clk);
    chk("t2_rd_count", rd_log.size(), 1);
    if (rd_log.size() > 0) chk("t2_rd_cyc", rd_log[0], e + 1);
    chk("t2_wr_count", wr_log.size(), 1);
    chk_wr("t2_echo", 0, e + 4, 2'b00, 8'h41);
    chk("t2_rda", rda, 0);

    // FIFO full back-pressure
    clear_logs();
    tbr = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) send(8'h31 + 8'(i));
    repeat (40) @(negedge clk);
    chk("t3_rd_full", rd_log.size(), 4);
    chk("t3_rda_pending", rda, 1);
    chk("t3_no_wr", wr_log.size(), 0);
    tbr = 1'b1;
    repeat (60) @(negedge clk);
    chk("t3_rd_all", rd_log.size(), 5);
    chk("t3_wr_all", wr_log.size(), 5);
    for (int i = 0; i < 5; i++) chk_wr("t3_tx", i, -1, 2'b00, 8'h31 + 8'(i));

    // br_cfg change during a write
    clear_logs();
    @(negedge clk);
    send(8'h55);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = iocs && !iorw && ioaddr == 2'b00;
    end
    chk("t4_wr_seen", seen, 1);
    br_cfg = 2'b11;
    repeat (12) @(negedge clk);
    d = ref_div(38400); lo = d[7:0]; hi = d[15:8];
    chk_wr("t4_echo", 0, -1, 2'b00, 8'h55);
`ifdef SPART_DRV_BRCFG_TRACK_EN
    chk("t4_count", wr_log.size(), 3);
    chk_wr("t4_lo", 1, -1, 2'b10, lo);
    chk_wr("t4_hi", 2, -1, 2'b11, hi);
    if (wr_log.size() >= 3) chk("t4_consec", wr_log[2].c - wr_log[1].c, 1);
`else
    chk("t4_count", wr_log.size(), 1);
`endif

    // reset in the middle of a read
    clear_logs();
    @(negedge clk);
    send(8'h66);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = iocs && iorw;
    end
    chk("t5_rd_seen", seen, 1);
    rst = 1'b1;
    #1;
    chk("t5_iocs", iocs, 0);
    chk("t5_hiz", databus === 8'hzz, 1);
    rx_q.delete(); exp_q.delete(); rda = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    clear_logs();
    rel = cyc;
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("t5_count", wr_log.size(), 2);
    chk_wr("t5_lo", 0, rel + 1, 2'b10, lo);
    chk_wr("t5_hi", 1, rel + 2, 2'b11, hi);
    chk("t5_no_rd", rd_log.size(), 0);

    // random traffic against the echo scoreboard
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0 && rx_q.size() < 6) send(8'($urandom));
      tbr = ($urandom_range(9) < 6);
    end
    tbr = 1'b1;
    for (int i = 0; i < 400 && (exp_q.size() != 0); i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("drain_exp", exp_q.size(), 0);
    chk("drain_rx", rx_q.size(), 0);
    chk("drain_outst", outst, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
